// File: rtl/crc_unfold2_check_if.sv
// -----------------------------------------------------------------------------
// crc_unfold2_check_if
//
// Purpose : Handshake bundle between a codeword source / result sink and the
//           2-bit-per-clock CRC checker.
//
// Signals :
//   in_valid    source -> checker  codeword_in is valid
//   in_ready    checker -> source  checker can accept a codeword
//   codeword_in source -> checker  {data, crc}, MSB = highest-degree coefficient
//   out_valid   checker -> sink    result valid, held until taken
//   out_ready   sink -> checker    sink takes the result
//   syndrome    checker -> sink    codeword(y) mod g(y)
//   crc_ok      checker -> sink    1 when syndrome == 0
//   data_out    checker -> sink    data field of the checked codeword
//
// Modports: master = source/sink side (testbench), slave = checker.
// -----------------------------------------------------------------------------
interface crc_unfold2_check_if #(
  parameter int DATA_W = 6,
  parameter int CRC_W  = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W+CRC_W-1:0] codeword_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [CRC_W-1:0]        syndrome;
  logic                    crc_ok;
  logic [DATA_W-1:0]       data_out;

  modport master (
    output in_valid, codeword_in, out_ready,
    input  in_ready, out_valid, syndrome, crc_ok, data_out
  );

  modport slave (
    input  in_valid, codeword_in, out_ready,
    output in_ready, out_valid, syndrome, crc_ok, data_out
  );
endinterface

// File: rtl/crc_unfold2_check.sv
// -----------------------------------------------------------------------------
// crc_unfold2_check
//
// Purpose : Receive-side CRC checker. Divides a codeword by
//           g(y) = 1 + y + y^3 + y^5 two bits per clock (2-level unfolded
//           LFSR) and reports the syndrome, a pass flag and the data field.
//
// Ports   :
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   bus        crc_unfold2_check_if.slave (codeword in, result out)
//   err_count  [7:0] saturating count of failed results taken downstream
//              (only when CRC_CHK_ERRCNT_EN is defined)
//
// Configuration macro: CRC_CHK_ERRCNT_EN adds the err_count port and counter.
//
// Flow: IDLE accepts a codeword, SHIFT runs ceil(N/2) beats of two division
// steps each, DONE holds the result until out_ready.
// -----------------------------------------------------------------------------
module crc_unfold2_check #(
  parameter int               DATA_W = 6,
  parameter int               CRC_W  = 5,
  parameter logic [CRC_W-1:0] POLY   = 5'b01011
) (
  input  logic                 clk,
  input  logic                 reset,
  crc_unfold2_check_if.slave   bus
`ifdef CRC_CHK_ERRCNT_EN
  ,
  output logic [7:0]           err_count
`endif
);

  // Codeword geometry. A leading zero pad makes the length even so every
  // beat consumes exactly two bits; leading zeros do not change the remainder.
  localparam int CW_W    = DATA_W + CRC_W;
  localparam int PAD     = CW_W % 2;
  localparam int SHIFT_W = CW_W + PAD;
  localparam int BEATS   = SHIFT_W / 2;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [SHIFT_W-1:0]  r_shift;
  logic [CRC_W-1:0]    r_syn;
  logic [BEAT_W-1:0]   r_beat;
  logic [DATA_W-1:0]   r_data;
  logic                r_crc_ok;

  logic                w_accept;
  logic                w_take;
  logic                w_last_beat;
  logic [CRC_W-1:0]    w_syn_mid;
  logic [CRC_W-1:0]    w_syn_next;

  // One serial division step: shift the next codeword bit into the remainder
  // and subtract g(y) whenever the y^CRC_W term falls out of the top.
  function automatic logic [CRC_W-1:0] div_step(
    input logic [CRC_W-1:0] s,
    input logic             b
  );
    return {s[CRC_W-2:0], b} ^ (s[CRC_W-1] ? POLY : '0);
  endfunction

  // Two chained steps per clock: the high bit of the pair is the
  // higher-degree coefficient and is divided in first.
  assign w_syn_mid  = div_step(r_syn,     r_shift[SHIFT_W-1]);
  assign w_syn_next = div_step(w_syn_mid, r_shift[SHIFT_W-2]);

  assign w_accept    = (r_state == S_IDLE)  && bus.in_valid;
  assign w_take      = (r_state == S_DONE)  && bus.out_ready;
  assign w_last_beat = (r_state == S_SHIFT) && (r_beat == BEAT_W'(BEATS - 1));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps every path driven, so no
  // latch is inferred for w_state_next.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_next = S_SHIFT;
      S_SHIFT: if (w_last_beat)  w_state_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register, remainder, beat counter, result registers
  // ---------------------------------------------------------------------------
  // NOTE: these are a handful of flops, not a memory array, and the outputs
  // they drive must read as zero after reset, so all of them are reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift  <= '0;
      r_syn    <= '0;
      r_beat   <= '0;
      r_data   <= '0;
      r_crc_ok <= 1'b0;
    end else if (w_accept) begin
      r_shift  <= SHIFT_W'(bus.codeword_in);   // zero-extend = pad bits on top
      r_data   <= bus.codeword_in[CW_W-1:CRC_W];
      r_syn    <= '0;
      r_beat   <= '0;
    end else if (r_state == S_SHIFT) begin
      r_shift  <= {r_shift[SHIFT_W-3:0], 2'b00};
      r_syn    <= w_syn_next;
      // Hold the counter on the last beat; it is cleared by the next accept.
      if (!w_last_beat) r_beat <= r_beat + BEAT_W'(1);
      // Pass flag is settled together with the final remainder so it is
      // already stable when out_valid rises.
      if (w_last_beat)  r_crc_ok <= (w_syn_next == '0);
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.syndrome  = r_syn;
  assign bus.crc_ok    = r_crc_ok;
  assign bus.data_out  = r_data;

`ifdef CRC_CHK_ERRCNT_EN
  // ---------------------------------------------------------------------------
  // Saturating count of failed results; only reset clears it.
  // ---------------------------------------------------------------------------
  logic [7:0] r_err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count <= 8'd0;
    end else if (w_take && !r_crc_ok && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_crc_unfold2_check.sv
// -----------------------------------------------------------------------------
// tb_crc_unfold2_check
//
// Directed bench for crc_unfold2_check: a table of codewords with
// hand-computed syndromes, plus hand-written sequences for back-to-back
// accepts, backpressure, stray in_valid, reset mid-shift and (when
// CRC_CHK_ERRCNT_EN is defined) the error counter.
// -----------------------------------------------------------------------------
module tb_crc_unfold2_check;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  crc_unfold2_check_if #(.DATA_W(6), .CRC_W(5)) bus ();

`ifdef CRC_CHK_ERRCNT_EN
  logic [7:0] err_count;
`endif

  crc_unfold2_check dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CRC_CHK_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  typedef struct {
    logic [10:0] cw;
    logic [4:0]  syn;
    logic        ok;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [10:0] cw);
    bus.in_valid    = 1'b1;
    bus.codeword_in = cw;
    tick();
    bus.in_valid    = 1'b0;
  endtask

  // Edges until out_valid is seen, bounded.
  task automatic wait_result(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic quick(input logic [10:0] cw);
    int n;
    accept(cw);
    wait_result(n);
    if (n >= 20) check("quick_timeout", n, 6);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int          n;
    int          c1;
    int          c2;
    logic [4:0]  h_syn;
    logic        h_ok;
    logic [5:0]  h_data;

    // codeword, syndrome = codeword(y) mod (y^5+y^3+y+1), ok
    vecs[0]  = '{11'b100000_10011, 5'b00000, 1'b1};  // y^10 + its remainder
    vecs[1]  = '{11'b000001_01011, 5'b00000, 1'b1};  // y^5 + 01011
    vecs[2]  = '{11'b100001_11000, 5'b00000, 1'b1};
    vecs[3]  = '{11'b100000_10010, 5'b00001, 1'b0};  // bit 0 flipped
    vecs[4]  = '{11'b100000_10001, 5'b00010, 1'b0};  // bit 1 flipped
    vecs[5]  = '{11'b000000_00000, 5'b00000, 1'b1};
    vecs[6]  = '{11'b000000_10101, 5'b10101, 1'b0};  // below degree 5
    vecs[7]  = '{11'b000010_00000, 5'b10110, 1'b0};  // y^6
    vecs[8]  = '{11'b111111_00000, 5'b11011, 1'b0};  // y^5..y^10
    vecs[9]  = '{11'b010101_01010, 5'b11010, 1'b0};
    vecs[10] = '{11'b000000_10011, 5'b10011, 1'b0};  // MSB flipped

    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.codeword_in = '0;
    bus.out_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values held while idle.
    for (int i = 0; i < 10; i++) begin
      check("idle_in_ready",  bus.in_ready,  1);
      check("idle_out_valid", bus.out_valid, 0);
      check("idle_syndrome",  bus.syndrome,  0);
      check("idle_crc_ok",    bus.crc_ok,    0);
      check("idle_data_out",  bus.data_out,  0);
      tick();
    end

    // Table-driven vectors.
    for (int v = 0; v < 11; v++) begin
      accept(vecs[v].cw);
      check($sformatf("v%0d_busy", v), bus.in_ready, 0);
      wait_result(n);
      check($sformatf("v%0d_latency", v),  n,             6);
      check($sformatf("v%0d_syndrome", v), bus.syndrome,  vecs[v].syn);
      check($sformatf("v%0d_crc_ok", v),   bus.crc_ok,    vecs[v].ok);
      check($sformatf("v%0d_data", v),     bus.data_out,  vecs[v].cw[10:5]);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check($sformatf("v%0d_out_drop", v), bus.out_valid, 0);
      check($sformatf("v%0d_ready", v),    bus.in_ready,  1);
    end

    // Back-to-back with out_ready held high: accepts 8 clocks apart.
    bus.out_ready = 1'b1;
    accept(11'b000001_01011);
    c1 = cyc;
    wait_result(n);
    check("b2b0_crc_ok", bus.crc_ok, 1);
    tick();
    accept(11'b100001_11000);
    c2 = cyc;
    check("b2b_spacing", c2 - c1, 8);
    wait_result(n);
    check("b2b1_latency",  n,            6);
    check("b2b1_crc_ok",   bus.crc_ok,   1);
    check("b2b1_data",     bus.data_out, 6'b100001);
    tick();
    bus.out_ready = 1'b0;

    // Stray in_valid during SHIFT, then 5 cycles of backpressure in DONE.
    accept(11'b100000_10010);
    bus.in_valid    = 1'b1;
    bus.codeword_in = 11'b111111_00000;
    wait_result(n);
    bus.in_valid    = 1'b0;
    check("bp_latency",  n,            6);
    check("bp_syndrome", bus.syndrome, 5'b00001);
    check("bp_data",     bus.data_out, 6'b100000);
    h_syn  = bus.syndrome;
    h_ok   = bus.crc_ok;
    h_data = bus.data_out;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready",  bus.in_ready,  0);
      check("bp_syn_hold",  bus.syndrome,  h_syn);
      check("bp_ok_hold",   bus.crc_ok,    h_ok);
      check("bp_data_hold", bus.data_out,  h_data);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_taken", bus.out_valid, 0);
    check("bp_idle",  bus.in_ready,  1);
    // Results keep their last value in IDLE.
    check("bp_idle_syn", bus.syndrome, 5'b00001);

    // Reset in SHIFT beat 3 discards the codeword.
    accept(11'b100000_10011);
    tick();
    tick();
    tick();
    check("rst_mid_shift", bus.in_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_in_ready", bus.in_ready,  1);
    check("rst_syndrome", bus.syndrome,  0);
    check("rst_data",     bus.data_out,  0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b0) n++;
      tick();
    end
    check("rst_no_result", n, 0);

    // Reset and accept in the same cycle: reset wins.
    bus.in_valid    = 1'b1;
    bus.codeword_in = 11'b100000_10011;
    reset           = 1'b1;
    tick();
    reset           = 1'b0;
    bus.in_valid    = 1'b0;
    check("rst_vs_accept", bus.in_ready, 1);

    // Still works after the resets.
    accept(11'b100000_10001);
    wait_result(n);
    check("post_rst_latency",  n,            6);
    check("post_rst_syndrome", bus.syndrome, 5'b00010);
    check("post_rst_crc_ok",   bus.crc_ok,   0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

`ifdef CRC_CHK_ERRCNT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("errcnt_reset", err_count, 0);
    for (int i = 0; i < 3; i++) quick(11'b100000_10010);
    check("errcnt_3", err_count, 3);
    quick(11'b100000_10011);
    quick(11'b000001_01011);
    check("errcnt_good", err_count, 3);
    for (int i = 0; i < 297; i++) quick(11'b000000_10101);
    check("errcnt_sat", err_count, 255);
    quick(11'b000010_00000);
    check("errcnt_sat_hold", err_count, 255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
